// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and helpers for the data-memory arbiter.
//   - arb_state_e : arbiter FSM states
//   - BEATS       : byte beats per 32-bit word access
//   - REQ_CPU/DBG : requester index into req/grant vectors ({dbg,cpu})
//   - byte_lane() : big-endian byte select, beat 0 = bits [31:24]
package dmem_arb_pkg;

  localparam int BEATS   = 4;
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [1:0]  beat);
    logic [7:0] b;
    case (beat)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-input round-robin picker (combinational).
//   req        : request vector {dbg,cpu}
//   last_owner : 1 = dbg was granted last, 0 = cpu was granted last
//   win        : one-hot winner {dbg,cpu}, 00 when nobody requests
// On a tie the requester that did not own the memory last wins.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req[REQ_CPU] && req[REQ_DBG]) begin
      win = last_owner ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a byte-wide single-port memory between the cpu and
// dbg ports. Each word access is four big-endian byte beats.
//   clk, rst_n                 : clock, synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata  : cpu request (level, held until c_ready)
//   c_ready/c_rdata            : cpu one-cycle completion pulse / read word
//   d_*                        : same as c_* for the dbg port
//   m_en/m_we/m_addr/m_wdata   : memory byte command (registered)
//   m_rdata                    : memory read byte, valid cycle after m_en
//   grant                      : one-hot owner {dbg,cpu}, 00 when idle
//   busy                       : high whenever the FSM is not IDLE
// Handshake: a requester raises req and holds it with stable fields until
// it sees ready; fields are latched at grant, ready is a single-cycle pulse
// and req must drop in that cycle unless a further access is wanted.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ready,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  arb_state_e        state;
  logic [1:0]        beat;        // beat currently presented on m_*
  logic              owner;       // 1 = dbg owns the current access
  logic              last_owner;  // 1 = dbg was granted last
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [23:0]       asm_q;       // first three read bytes, base byte on top

  logic [1:0]        winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  dmem_rr_pick u_pick (
    .req        ({d_req, c_req}),
    .last_owner (last_owner),
    .win        (winner)
  );

  always_comb begin
    sel_we    = c_we;
    sel_addr  = c_addr;
    sel_wdata = c_wdata;
    if (winner[REQ_DBG]) begin
      sel_we    = d_we;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      beat       <= 2'd0;
      owner      <= 1'b0;
      last_owner <= 1'b1;  // cpu wins the first tie
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      asm_q      <= '0;
      c_ready    <= 1'b0;
      d_ready    <= 1'b0;
      c_rdata    <= '0;
      d_rdata    <= '0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|winner) begin
            state      <= ST_XFER;
            beat       <= 2'd0;
            owner      <= winner[REQ_DBG];
            last_owner <= winner[REQ_DBG];
            lat_we     <= sel_we;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            grant      <= winner;
            busy       <= 1'b1;
            m_en       <= 1'b1;
            m_we       <= sel_we;
            m_addr     <= sel_addr;
            m_wdata    <= byte_lane(sel_wdata, 2'd0);
          end
        end

        ST_XFER: begin
          // Read data trails its address by one cycle, so beats 1..3 of the
          // address phase collect bytes 0..2.
          if (!lat_we && beat != 2'd0) begin
            asm_q <= {asm_q[15:0], m_rdata};
          end
          if (beat == 2'(BEATS - 1)) begin
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            if (lat_we) begin
              state   <= ST_RESP;
              c_ready <= !owner;
              d_ready <= owner;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            beat    <= beat + 2'd1;
            m_addr  <= lat_addr + ADDR_W'(beat) + ADDR_W'(1);
            m_wdata <= byte_lane(lat_wdata, beat + 2'd1);
          end
        end

        ST_DRAIN: begin
          state   <= ST_RESP;
          c_ready <= !owner;
          d_ready <= owner;
          if (owner) d_rdata <= {asm_q, m_rdata};
          else       c_rdata <= {asm_q, m_rdata};
        end

        ST_RESP: begin
          state   <= ST_IDLE;
          c_ready <= 1'b0;
          d_ready <= 1'b0;
          grant   <= 2'b00;
          busy    <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a byte memory,
// a transaction-timeline reference model and per-cycle output checks.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [4:0]  c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_ready, d_ready;
  logic [31:0] c_rdata, d_rdata;
  logic        m_en, m_we;
  logic [4:0]  m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic [1:0]  grant;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .grant(grant), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- byte memory (registered read) ----------------
  logic [7:0] tb_mem [32];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) tb_mem[m_addr] <= m_wdata;
      else      m_rdata <= tb_mem[m_addr];
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An access is a timeline counted from its grant edge: cycles 1..4 carry
  // byte beats, the ready pulse lands in cycle 5 (write) or 6 (read), and the
  // cycle after that is a dead IDLE cycle before requests are looked at again.
  logic [7:0]  mm [32];
  bit          md_valid = 0, md_reset, md_active, md_last, md_owner, md_we;
  int          md_k, md_end;
  logic [4:0]  md_base, ma;
  logic [31:0] md_wdata, md_word;
  logic [31:0] md_rdata [2];
  logic        e_m_en, e_m_we, e_c_ready, e_d_ready, e_busy;
  logic [4:0]  e_m_addr;
  logic [7:0]  e_m_wdata;
  logic [1:0]  e_grant;

  always @(posedge clk) begin
    if (!rst_n) begin
      md_valid = 1; md_reset = 1; md_active = 0; md_last = 1;
      md_rdata[0] = 0; md_rdata[1] = 0;
    end else begin
      md_reset = 0;
      if (md_active) begin
        if (md_k == md_end) md_active = 0;
        else md_k++;
      end else if (c_req || d_req) begin
        if (c_req && d_req) md_owner = md_last ? 1'b0 : 1'b1;
        else                md_owner = d_req;
        md_last  = md_owner;
        md_we    = md_owner ? d_we : c_we;
        md_base  = md_owner ? d_addr : c_addr;
        md_wdata = md_owner ? d_wdata : c_wdata;
        md_k = 1; md_end = md_we ? 5 : 6; md_active = 1;
        md_word = 0;
        for (int i = 0; i < 4; i++) begin
          ma = md_base + 5'(i);
          md_word = (md_word << 8) | 32'(mm[ma]);
        end
      end
    end
    e_busy    = md_active;
    e_grant   = !md_active ? 2'b00 : (md_owner ? 2'b10 : 2'b01);
    e_m_en    = md_active && md_k <= 4;
    e_m_we    = e_m_en && md_we;
    e_m_addr  = e_m_en ? md_base + 5'(md_k - 1) : 5'd0;
    e_m_wdata = e_m_en ? 8'((md_wdata >> (8 * (4 - md_k))) & 32'hff) : 8'd0;
    if (e_m_we) mm[e_m_addr] = e_m_wdata;
    e_c_ready = md_active && md_k == md_end && !md_owner;
    e_d_ready = md_active && md_k == md_end && md_owner;
    if ((e_c_ready || e_d_ready) && !md_we) md_rdata[md_owner] = md_word;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (md_valid) begin
      chk("c_ready", 32'(c_ready), 32'(e_c_ready));
      chk("d_ready", 32'(d_ready), 32'(e_d_ready));
      chk("c_rdata", c_rdata, md_rdata[0]);
      chk("d_rdata", d_rdata, md_rdata[1]);
      chk("m_en", 32'(m_en), 32'(e_m_en));
      chk("grant", 32'(grant), 32'(e_grant));
      chk("busy", 32'(busy), 32'(e_busy));
      if (e_m_en || md_reset) begin
        chk("m_we", 32'(m_we), 32'(e_m_we));
        chk("m_addr", 32'(m_addr), 32'(e_m_addr));
        chk("m_wdata", 32'(m_wdata), 32'(e_m_wdata));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic access(input bit who, input bit we, input logic [4:0] a,
                        input logic [31:0] d, output int lat);
    bit seen;
    @(negedge clk);
    if (who) begin d_req = 1; d_we = we; d_addr = a; d_wdata = d; end
    else     begin c_req = 1; c_we = we; c_addr = a; c_wdata = d; end
    lat = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = who ? d_ready : c_ready;
    end
    if (who) d_req = 0; else c_req = 0;
    if (!seen) chk("ready_timeout", 32'(lat), 32'd0);
  endtask

  task automatic wait_ready_cpu(output int lat);
    bit seen;
    lat = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = c_ready;
    end
    if (!seen) chk("held_timeout", 32'(lat), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int l1, l2;
  initial begin
    for (int i = 0; i < 32; i++) begin tb_mem[i] = 8'h00; mm[i] = 8'h00; end
    rst_n = 0; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // cpu write then read-back
    access(0, 1, 5'd4, 32'hA1B2C3D4, l1);
    chk("wr_latency", 32'(l1), 32'd5);
    chk("mem4", 32'(tb_mem[4]), 32'hA1);
    chk("mem5", 32'(tb_mem[5]), 32'hB2);
    chk("mem6", 32'(tb_mem[6]), 32'hC3);
    chk("mem7", 32'(tb_mem[7]), 32'hD4);
    access(0, 0, 5'd4, 32'h0, l1);
    chk("rd_latency", 32'(l1), 32'd6);
    chk("cpu_rd4", c_rdata, 32'hA1B2C3D4);

    // dbg write with address wrap, then read-back
    access(1, 1, 5'd30, 32'h11223344, l1);
    chk("wrap_wr_latency", 32'(l1), 32'd5);
    chk("mem30", 32'(tb_mem[30]), 32'h11);
    chk("mem31", 32'(tb_mem[31]), 32'h22);
    chk("mem0", 32'(tb_mem[0]), 32'h33);
    chk("mem1", 32'(tb_mem[1]), 32'h44);
    access(1, 0, 5'd30, 32'h0, l1);
    chk("dbg_rd30", d_rdata, 32'h11223344);

    // tie after a dbg grant: cpu first, dbg in the IDLE cycle after cpu RESP
    fork
      access(0, 1, 5'd12, 32'h55667788, l1);
      access(1, 1, 5'd16, 32'h99AABBCC, l2);
    join
    chk("tie1_cpu_lat", 32'(l1), 32'd5);
    chk("tie1_dbg_lat", 32'(l2), 32'd11);

    // cpu solo access makes cpu last owner, so the next tie goes to dbg
    access(0, 0, 5'd12, 32'h0, l1);
    chk("cpu_rd12", c_rdata, 32'h55667788);
    fork
      access(0, 0, 5'd16, 32'h0, l1);
      access(1, 0, 5'd12, 32'h0, l2);
    join
    chk("tie2_dbg_lat", 32'(l2), 32'd6);
    chk("tie2_cpu_lat", 32'(l1), 32'd13);
    chk("tie2_dbg_data", d_rdata, 32'h55667788);
    chk("tie2_cpu_data", c_rdata, 32'h99AABBCC);

    // req held past ready starts a second identical access
    @(negedge clk);
    c_req = 1; c_we = 1; c_addr = 5'd20; c_wdata = 32'h0F1E2D3C;
    wait_ready_cpu(l1);
    chk("held_first_lat", 32'(l1), 32'd5);
    wait_ready_cpu(l2);
    c_req = 0;
    chk("held_gap", 32'(l2), 32'd6);
    chk("mem20", 32'(tb_mem[20]), 32'h0F);
    chk("mem23", 32'(tb_mem[23]), 32'h3C);

    // reset after beat 1 of a write: only two bytes land
    @(negedge clk);
    c_req = 1; c_we = 1; c_addr = 5'd8; c_wdata = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0; c_req = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_c_rdata", c_rdata, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("mem8", 32'(tb_mem[8]), 32'hDE);
    chk("mem9", 32'(tb_mem[9]), 32'hAD);
    chk("mem10", 32'(tb_mem[10]), 32'h00);
    chk("mem11", 32'(tb_mem[11]), 32'h00);
    repeat (2) @(negedge clk);
    access(0, 0, 5'd8, 32'h0, l1);
    chk("post_abort_rd", c_rdata, 32'hDEAD0000);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, byte-wide 32-entry data memory between two requesters: the processor core port (cpu) and a debug/loader port (dbg).
- Each 32-bit word access is sequenced as four byte beats, in big-endian order, with round-robin arbitration.
- Sits between the core's load/store path and the byte memory.
- The core stalls until its ready pulse.

Parameters:
- ADDR_W, 5, byte address width; memory depth is 2**ADDR_W.
- DATA_W, 32, requester word width; must equal 4*8.
- BEATS, 4, byte beats per word access.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- c_req  in  1  cpu access request; level, held until c_ready.
- c_we  in  1  cpu write(1)/read(0).
- c_addr  in  ADDR_W  cpu byte base address.
- c_wdata  in  DATA_W  cpu write word.
- c_ready  out  1  one-cycle completion pulse to cpu.
- c_rdata  out  DATA_W  cpu read word, valid with c_ready, held until the next cpu read completes.
- d_req, d_we, d_addr, d_wdata, d_ready, d_rdata: same as the c_* ports, for dbg.
- m_en  out  1  memory enable for this cycle.
- m_we  out  1  memory byte write.
- m_addr  out  ADDR_W  memory byte address.
- m_wdata  out  8  memory write byte.
- m_rdata  in  8  memory read byte; registered, valid the cycle after m_en with m_we=0.
- grant  out  2  one-hot owner {dbg,cpu}; 00 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, beat=0.
  - c_ready=d_ready=0, c_rdata=d_rdata=0.
  - m_en=m_we=0, m_addr=0, m_wdata=0.
  - grant=00, busy=0.
  - last_owner=dbg, so cpu wins the first tie.
- States are IDLE, XFER, DRAIN and RESP. All outputs are registered.
- IDLE:
  - If any req is sampled high, latch the winner's we/addr/wdata, set grant and go to XFER with beat=0.
  - On a tie, the requester that is not last_owner wins. last_owner updates at grant.
  - The loser keeps waiting; its req must stay high.
- XFER, four cycles (beat 0..3):
  - m_en=1, m_we=latched we.
  - m_addr=(base+beat) mod 2**ADDR_W, so addresses wrap (e.g. base 30 gives 30,31,0,1).
  - m_wdata=wdata byte [31-8*beat -: 8].
  - After beat 3: a write goes to RESP; a read goes to DRAIN.
- Read capture: the byte for beat k is shifted into the assembly register in the cycle after its address (beats 1..3 during XFER, beat 3 during DRAIN). The byte from base lands in bits [31:24].
- DRAIN: one cycle, m_en=0. The final byte is captured, then go to RESP.
- RESP:
  - The granted requester's ready=1 for exactly one cycle. For reads, its rdata is updated in the same cycle.
  - grant drops and the FSM returns to IDLE.
  - req is not sampled in RESP.
- Latency from the req-sampling edge to the ready cycle: write 5 cycles, read 6 cycles.
- Back-to-back: a requester must drop req in the cycle ready is high. A req still high in the IDLE cycle after RESP is a new access.
- The other requester's pending req is served in the IDLE cycle directly after RESP, giving alternation under continuous contention.
- Input changes after grant are ignored (fields are latched).
- A reset during XFER aborts the access:
  - Bytes already written stay in memory.
  - No ready is generated.
  - rdata resets to 0.
- Holding req low in IDLE keeps all memory outputs quiet (m_en=0).

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, XFER, DRAIN, RESP);
  - BEATS=4;
  - requester id constants (REQ_CPU=0, REQ_DBG=1);
  - the byte lane select function.
- One sub-module, dmem_rr_pick: 2-input round-robin picker.
  - Inputs: req vector, last_owner.
  - Output: one-hot winner.
  - Purely combinational; the registered last_owner lives in the parent.

Test Plan:
- Reset, then cpu write addr 4, data 0xA1B2C3D4 → memory writes in consecutive cycles: 4=A1, 5=B2, 6=C3, 7=D4; c_ready in cycle 5; grant=01 during the access.
- cpu read addr 4 after the above → c_rdata=0xA1B2C3D4 with c_ready in cycle 6; m_we=0 throughout.
- Wrap: dbg write addr 30, data 0x11223344 → writes 30=11, 31=22, 0=33, 1=44; a dbg read from 30 returns 0x11223344.
- Tie: c_req and d_req rise together after reset → cpu served first, dbg granted in the IDLE cycle after the cpu RESP. Repeat the tie → order alternates.
- Reset mid-XFER (after beat 1 of a write 0xDEADBEEF to addr 8) → only 8=DE and 9=AD are written; no ready pulse; all outputs are at reset values on the next cycle.
- Held req: cpu keeps c_req high for one cycle after c_ready → a second, identical access is performed, with ready again after 5 or 6 cycles.
